// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game flow controller and its helpers.
package game_flow_pkg;

  // Game sequencer states; the encoding doubles as the OLED source select.
  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEATH = 2'd2,
    ST_CLEAR = 2'd3
  } game_state_e;

  localparam logic [1:0] OLED_SEL_MENU  = 2'd0;
  localparam logic [1:0] OLED_SEL_GAME  = 2'd1;
  localparam logic [1:0] OLED_SEL_DEATH = 2'd2;
  localparam logic [1:0] OLED_SEL_CLEAR = 2'd3;

  localparam int SCORE_W      = 14;
  localparam int FRAME_PIXELS = 6144;
  localparam int PIX_W        = $clog2(FRAME_PIXELS);

  // Map a game state onto the screen that should be shown for it.
  function automatic logic [1:0] sel_for_state(game_state_e s);
    case (s)
      ST_MENU:  return OLED_SEL_MENU;
      ST_PLAY:  return OLED_SEL_GAME;
      ST_DEATH: return OLED_SEL_DEATH;
      ST_CLEAR: return OLED_SEL_CLEAR;
      default:  return OLED_SEL_MENU;
    endcase
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stability counter for a raw push button.
// btn_press is a one-cycle pulse on the debounced rising edge; it is decoded
// purely from flops so the consumer sees a clean single-cycle strobe.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // accepted level; accept the new level once it has held long enough.
  always_comb begin
    sync_d    = {sync_q[0], btn_raw};
    stable_d  = stable_q;
    cnt_d     = '0;
    btn_press = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync_q[1];
        btn_press = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, accepted level and stability counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: menu/play/end-screen flow, per-frame collision
// events, shield and speed power-up timing, score counting and OLED select.
// It is the only driver of return_to_menu.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int SCORE_TICK_CYCLES = 100_000_000,
  parameter int CLEAR_SCORE       = 100,
  parameter int SPEED_CYCLES      = 300_000_000,
  parameter int HOLD_CYCLES       = 50_000_000
) (
  input  logic               clock_100mhz,
  input  logic               rst_n,
  input  logic               btnC,
  input  logic [PIX_W-1:0]   pixel_index,
  input  logic               is_collision,
  input  logic               is_speed_collision,
  input  logic               is_shield_collision,
  output logic               game_active,
  output logic               speed_active,
  output logic               shield_active,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         oled_sel,
  output logic               return_to_menu
);

  localparam int TICK_W = $clog2(SCORE_TICK_CYCLES + 1);
  localparam int SPD_W  = $clog2(SPEED_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCORE_TICK_CYCLES - 1);
  localparam logic [SPD_W-1:0]   SPD_RELOAD = SPD_W'(SPEED_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_DONE  = HOLD_W'(HOLD_CYCLES);
  localparam logic [SCORE_W-1:0] CLEAR_VAL  = SCORE_W'(CLEAR_SCORE);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic               shield_q, shield_d;
  logic               hit_l_q, hit_l_d;
  logic               spd_l_q, spd_l_d;
  logic               shd_l_q, shd_l_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rtm_q, rtm_d;
  logic               game_active_q, game_active_d;
  logic [PIX_W-1:0]   prev_pix_q, prev_pix_d;

  logic               btn_press;
  logic               frame_start;
  logic               death_hit;
  logic               clear_hit;
  logic [SCORE_W:0]   score_inc;
  logic [SCORE_W:0]   score_sum;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_c (
    .clk      (clock_100mhz),
    .rst_n    (rst_n),
    .btn_raw  (btnC),
    .btn_press(btn_press)
  );

  // A frame begins when the scan returns to pixel 0 from any other pixel.
  always_comb begin
    prev_pix_d  = pixel_index;
    frame_start = (pixel_index == '0) && (prev_pix_q != '0);
  end

  // Next-state logic: game flow, frame events, power-ups, score and hold time.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    tick_d    = tick_q;
    speed_d   = speed_q;
    shield_d  = shield_q;
    hit_l_d   = hit_l_q;
    spd_l_d   = spd_l_q;
    shd_l_d   = shd_l_q;
    hold_d    = hold_q;
    rtm_d     = 1'b0;
    death_hit = 1'b0;
    clear_hit = 1'b0;
    score_inc = (speed_q != '0) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);
    score_sum = {1'b0, score_q} + score_inc;

    case (state_q)
      ST_MENU: begin
        hit_l_d = 1'b0;
        spd_l_d = 1'b0;
        shd_l_d = 1'b0;
        if (btn_press) begin
          state_d  = ST_PLAY;
          score_d  = '0;
          tick_d   = '0;
          speed_d  = '0;
          shield_d = 1'b0;
        end
      end

      ST_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (score_sum >= {1'b0, CLEAR_VAL}) begin
            score_d   = CLEAR_VAL;
            clear_hit = 1'b1;
          end else begin
            score_d = score_sum[SCORE_W-1:0];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end

        if (frame_start && spd_l_q) begin
          speed_d = SPD_RELOAD;
        end else if (speed_q != '0) begin
          speed_d = speed_q - 1'b1;
        end

        // The hit is judged against the shield held before this frame's pickup.
        if (frame_start) begin
          if (hit_l_q) begin
            if (shield_q) begin
              shield_d = 1'b0;
            end else begin
              death_hit = 1'b1;
            end
          end
          if (shd_l_q) begin
            shield_d = 1'b1;
          end
        end

        if (frame_start) begin
          hit_l_d = is_collision;
          spd_l_d = is_speed_collision;
          shd_l_d = is_shield_collision;
        end else begin
          hit_l_d = hit_l_q | is_collision;
          spd_l_d = spd_l_q | is_speed_collision;
          shd_l_d = shd_l_q | is_shield_collision;
        end

        if (death_hit) begin
          state_d = ST_DEATH;
        end else if (clear_hit) begin
          state_d = ST_CLEAR;
        end

        if (death_hit || clear_hit) begin
          speed_d  = '0;
          shield_d = 1'b0;
          hold_d   = '0;
          hit_l_d  = 1'b0;
          spd_l_d  = 1'b0;
          shd_l_d  = 1'b0;
        end
      end

      ST_DEATH, ST_CLEAR: begin
        hit_l_d = 1'b0;
        spd_l_d = 1'b0;
        shd_l_d = 1'b0;
        if (hold_q != HOLD_DONE) begin
          hold_d = hold_q + 1'b1;
        end else if (btn_press) begin
          state_d = ST_MENU;
          rtm_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_MENU;
      end
    endcase

    game_active_d = (state_d == ST_PLAY);
  end

  // State, counters, latches and registered outputs.
  always_ff @(posedge clock_100mhz) begin
    if (!rst_n) begin
      state_q       <= ST_MENU;
      score_q       <= '0;
      tick_q        <= '0;
      speed_q       <= '0;
      shield_q      <= 1'b0;
      hit_l_q       <= 1'b0;
      spd_l_q       <= 1'b0;
      shd_l_q       <= 1'b0;
      hold_q        <= '0;
      rtm_q         <= 1'b0;
      game_active_q <= 1'b0;
      prev_pix_q    <= '0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      tick_q        <= tick_d;
      speed_q       <= speed_d;
      shield_q      <= shield_d;
      hit_l_q       <= hit_l_d;
      spd_l_q       <= spd_l_d;
      shd_l_q       <= shd_l_d;
      hold_q        <= hold_d;
      rtm_q         <= rtm_d;
      game_active_q <= game_active_d;
      prev_pix_q    <= prev_pix_d;
    end
  end

  assign game_active    = game_active_q;
  assign speed_active   = (speed_q != '0);
  assign shield_active  = shield_q;
  assign score          = score_q;
  assign oled_sel       = sel_for_state(state_q);
  assign return_to_menu = rtm_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Randomised bench for game_flow_controller with a cycle-level behavioural model.
module tb_game_flow_controller;
  import game_flow_pkg::*;

  localparam int DEB  = 4;
  localparam int TICK = 10;
  localparam int CLR  = 5;
  localparam int SPD  = 40;
  localparam int HOLD = 8;

  localparam int S_MENU  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_DEATH = 2;
  localparam int S_CLEAR = 3;

  logic        clock_100mhz = 1'b0;
  logic        rst_n;
  logic        btnC;
  logic [12:0] pixel_index;
  logic        is_collision;
  logic        is_speed_collision;
  logic        is_shield_collision;
  logic        game_active;
  logic        speed_active;
  logic        shield_active;
  logic [13:0] score;
  logic [1:0]  oled_sel;
  logic        return_to_menu;

  int compared   = 0;
  int mismatched = 0;

  int pix            = 0;
  int frame_len      = FRAME_PIXELS;
  int next_frame_len = FRAME_PIXELS;

  int m_state, m_score, m_tick, m_speed_left, m_end_cycles, m_prev_pix;
  bit m_shield, m_hit_seen, m_spd_seen, m_shd_seen, m_rtm, m_stable;
  bit hist[6];

  int deaths = 0, clears = 0, saves = 0, speed_ticks = 0;

  game_flow_controller #(
    .DEBOUNCE_CYCLES  (DEB),
    .SCORE_TICK_CYCLES(TICK),
    .CLEAR_SCORE      (CLR),
    .SPEED_CYCLES     (SPD),
    .HOLD_CYCLES      (HOLD)
  ) dut (
    .clock_100mhz       (clock_100mhz),
    .rst_n              (rst_n),
    .btnC               (btnC),
    .pixel_index        (pixel_index),
    .is_collision       (is_collision),
    .is_speed_collision (is_speed_collision),
    .is_shield_collision(is_shield_collision),
    .game_active        (game_active),
    .speed_active       (speed_active),
    .shield_active      (shield_active),
    .score              (score),
    .oled_sel           (oled_sel),
    .return_to_menu     (return_to_menu)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: observed %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Reference model: advances one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit press, flip, fs, dead, done, speed_on;
    int sum;
    if (!rst_n) begin
      m_state = S_MENU; m_score = 0; m_tick = 0; m_speed_left = 0; m_end_cycles = 0;
      m_shield = 0; m_hit_seen = 0; m_spd_seen = 0; m_shd_seen = 0; m_rtm = 0;
      m_stable = 0; m_prev_pix = 0;
      for (int i = 0; i < 6; i++) hist[i] = 1'b0;
      return;
    end
    // Button: accepted level flips once the synchronised level (two samples
    // late) has disagreed with it for DEB consecutive samples.
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btnC;
    flip = 1'b1;
    for (int i = 0; i < DEB; i++) if (hist[2+i] == m_stable) flip = 1'b0;
    press = 1'b0;
    if (flip) begin
      m_stable = !m_stable;
      press = m_stable;
    end
    fs = (pixel_index == 0) && (m_prev_pix != 0);
    m_prev_pix = pixel_index;
    m_rtm = 1'b0;
    case (m_state)
      S_MENU: begin
        m_hit_seen = 0; m_spd_seen = 0; m_shd_seen = 0;
        if (press) begin
          m_state = S_PLAY; m_score = 0; m_tick = 0; m_speed_left = 0; m_shield = 0;
        end
      end
      S_PLAY: begin
        dead = 0; done = 0;
        speed_on = (m_speed_left != 0);
        m_tick++;
        if (m_tick == TICK) begin
          m_tick = 0;
          if (speed_on) speed_ticks++;
          sum = m_score + (speed_on ? 2 : 1);
          if (sum >= CLR) begin m_score = CLR; done = 1; end
          else m_score = sum;
        end
        if (fs && m_spd_seen) m_speed_left = SPD - 1;
        else if (m_speed_left > 0) m_speed_left--;
        if (fs) begin
          if (m_hit_seen) begin
            if (m_shield) begin m_shield = 0; saves++; end
            else dead = 1;
          end
          if (m_shd_seen) m_shield = 1;
          m_hit_seen = is_collision; m_spd_seen = is_speed_collision; m_shd_seen = is_shield_collision;
        end else begin
          m_hit_seen |= is_collision; m_spd_seen |= is_speed_collision; m_shd_seen |= is_shield_collision;
        end
        if (dead) begin m_state = S_DEATH; deaths++; end
        else if (done) begin m_state = S_CLEAR; clears++; end
        if (dead || done) begin m_speed_left = 0; m_shield = 0; m_end_cycles = 0; end
      end
      default: begin
        m_hit_seen = 0; m_spd_seen = 0; m_shd_seen = 0;
        if (m_end_cycles >= HOLD) begin
          if (press) begin m_state = S_MENU; m_rtm = 1; end
        end else begin
          m_end_cycles++;
        end
      end
    endcase
  endtask

  task automatic compareAll();
    checkOutput("oled_sel", int'(oled_sel), m_state);
    checkOutput("game_active", int'(game_active), int'(m_state == S_PLAY));
    checkOutput("score", int'(score), m_score);
    checkOutput("speed_active", int'(speed_active), int'(m_speed_left != 0));
    checkOutput("shield_active", int'(shield_active), int'(m_shield));
    checkOutput("return_to_menu", int'(return_to_menu), int'(m_rtm));
  endtask

  // Drive one cycle of inputs, let the DUT and model take the edge, then compare.
  task automatic applyStimulus(input bit r, input bit b, input bit h, input bit s, input bit d);
    rst_n = r; btnC = b;
    is_collision = h; is_speed_collision = s; is_shield_collision = d;
    pixel_index = pix[12:0];
    pix++;
    if (pix >= frame_len) begin
      pix = 0;
      frame_len = next_frame_len;
    end
    @(posedge clock_100mhz);
    modelStep();
    @(negedge clock_100mhz);
    compareAll();
  endtask

  initial begin
    int n;
    bit seen_rtm;
    bit btn_level;
    int btn_left;

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_oled_sel", int'(oled_sel), S_MENU);
    repeat (6) applyStimulus(1, 0, 0, 0, 0);

    // A 3-cycle glitch must not be accepted as a press.
    repeat (3) applyStimulus(1, 1, 0, 0, 0);
    repeat (10) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("bounce_ignored", int'(oled_sel), S_MENU);

    n = 0;
    do begin
      applyStimulus(1, 1, 0, 0, 0);
      n++;
    end while (!game_active && n < 20);
    checkOutput("press_latency", n, 6);

    repeat (60) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clear_sel", int'(oled_sel), S_CLEAR);
    checkOutput("clear_score", int'(score), CLR);

    n = 0;
    seen_rtm = 1'b0;
    do begin
      applyStimulus(1, 1, 0, 0, 0);
      n++;
      if (return_to_menu) seen_rtm = 1'b1;
    end while (!seen_rtm && n < 20);
    checkOutput("rtm_seen", int'(seen_rtm), 1);
    repeat (8) applyStimulus(1, 0, 0, 0, 0);

    n = 0;
    do begin
      applyStimulus(1, 1, 0, 0, 0);
      n++;
    end while (!game_active && n < 20);
    checkOutput("replay_latency", n, 6);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midreset_sel", int'(oled_sel), S_MENU);
    checkOutput("midreset_active", int'(game_active), 0);
    checkOutput("midreset_score", int'(score), 0);

    btn_level = 1'b0;
    btn_left = 0;
    for (int i = 0; i < 14000; i++) begin
      if (btn_left == 0) begin
        btn_level = !btn_level;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      next_frame_len = $urandom_range(4, 16);
      applyStimulus(($urandom_range(0, 1499) != 0), btn_level,
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 29) == 0));
    end

    $display("[TB] deaths=%0d clears=%0d shield_saves=%0d speed_ticks=%0d",
             deaths, clears, saves, speed_ticks);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
